// File: rtl/adder_multi_bit_full_adder.sv
// One-bit full-adder cell: the ripple element of adder_multi_bit.
// Purely combinational; the carry chain is formed by the parent.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_multi_bit.sv
// Parameterised unsigned ripple-carry adder, {Cout,Sum} = A + B + Cin,
// with the result registered once; one add per cycle, latency 1.
module adder_multi_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // Result registers load only on a valid add, so idle cycles never
  // pull unused operand values into the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s;
        Cout <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_adder_multi_bit.sv
// Self-checking bench for adder_multi_bit: directed corner cases plus a
// random stream scored against a plain-arithmetic reference, at WIDTH 8/1/32.
module tb_adder_multi_bit;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, cout8, ov8;

  logic        v1, a1, b1, cin1, sum1, cout1, ov1;

  logic        v32, cin32, cout32, ov32;
  logic [31:0] a32, b32, sum32;

  int n_cmp;
  int n_err;

  adder_multi_bit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a8), .B(b8), .Cin(cin8),
    .out_valid(ov8), .Sum(sum8), .Cout(cout8)
  );

  adder_multi_bit #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(cin1),
    .out_valid(ov1), .Sum(sum1), .Cout(cout1)
  );

  adder_multi_bit #(.WIDTH(32)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .A(a32), .B(b32), .Cin(cin32),
    .out_valid(ov32), .Sum(sum32), .Cout(cout32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact WIDTH+1-bit total from ordinary integer addition.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int unsigned t;
    t = int'(a) + int'(b) + int'(cin);
    return t[8:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin);
    in_valid = 1'b1;
    a8       = a;
    b8       = b;
    cin8     = cin;
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [8:0] exp);
    drive(a, b, cin);
    tick();
    check({tag, "_sum"}, 64'(sum8), 64'(exp[7:0]));
    check({tag, "_cout"}, 64'(cout8), 64'(exp[8]));
    check({tag, "_ov"}, 64'(ov8), 64'd1);
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] last;
  logic [8:0] e;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(8'hFF, 8'h01, 1'b1);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'd1; cin32 = 1'b0;

    // Reset held across edges with valid inputs present.
    repeat (3) tick();
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_ov", 64'(ov8), 64'd0);
    check("rst_w32", 64'({ov32, cout32, sum32}), 64'd0);

    #3 rst_n = 1'b1;
    // First capture on the first rising edge after release.
    drive(8'd200, 8'd100, 1'b1);
    tick();
    check("basic_sum", 64'(sum8), 64'd45);
    check("basic_cout", 64'(cout8), 64'd1);
    check("basic_total", 64'({cout8, sum8}), 64'd301);
    check("basic_ov", 64'(ov8), 64'd1);
    check("w1_sum", 64'(sum1), 64'd1);
    check("w1_cout", 64'(cout1), 64'd1);
    check("w32_sum", 64'(sum32), 64'd0);
    check("w32_cout", 64'(cout32), 64'd1);
    check("w32_ov", 64'(ov32), 64'd1);
    v1 = 1'b0;
    v32 = 1'b0;

    directed("ripple_ff", 8'd255, 8'd0, 1'b1, 9'h100);
    directed("ripple_7f", 8'd127, 8'd1, 1'b0, 9'd128);
    directed("wrap_max", 8'd255, 8'd255, 1'b1, 9'h1FF);
    directed("zero", 8'd0, 8'd0, 1'b0, 9'd0);

    // Back-to-back random stream, each result one cycle after its inputs.
    for (int i = 0; i < 15; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_add(ra, rb, rc));
      drive(ra, rb, rc);
      tick();
      e = exp_q.pop_front();
      check($sformatf("stream%0d_total", i), 64'({cout8, sum8}), 64'(e));
      check($sformatf("stream%0d_ov", i), 64'(ov8), 64'd1);
      last = e;
    end

    // Idle: outputs hold while operands keep changing.
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("idle%0d_total", i), 64'({cout8, sum8}), 64'(last));
      check($sformatf("idle%0d_ov", i), 64'(ov8), 64'd0);
    end

    // Mid-stream asynchronous reset, asserted between edges.
    directed("pre_rst", 8'd240, 8'd32, 1'b0, 9'd272);
    drive(8'd77, 8'd99, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_total", 64'({cout8, sum8}), 64'd0);
    check("async_rst_ov", 64'(ov8), 64'd0);
    tick();
    check("rst_hold_total", 64'({cout8, sum8}), 64'd0);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_idle_total", 64'({cout8, sum8}), 64'd0);
    check("post_rst_idle_ov", 64'(ov8), 64'd0);
    directed("post_rst", 8'd77, 8'd99, 1'b1, ref_add(8'd77, 8'd99, 1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
